// File: rtl/program_loader.sv
// program_loader: accepts a stream of ASCII program characters, keeps only
// the eight command bytes, and writes them into a 2^ADDR_WIDTH byte program
// memory followed by a 0x00 terminator. Bracket nesting and capacity are
// checked while loading; any violation ends the session with an error code.
//
// Ports:
//   clk          sole clock, rising edge
//   reset_n      asynchronous active-low reset
//   start        begin a load session (sampled only in IDLE)
//   in_data      incoming program character
//   in_valid     in_data valid this cycle
//   in_ready     loader accepts in_data this cycle (high only in LOAD)
//   mem_wr_en    program memory write strobe
//   mem_addr     write address
//   mem_wr_data  write data
//   busy         session in progress (LOAD or TERM)
//   done         one-cycle pulse at end of session
//   error        session failed; held until next accepted start
//   err_code     00 none, 01 overflow, 10 unmatched ']', 11 unmatched '['
//   prog_len     command bytes written, terminator excluded
module program_loader #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH:0]   prog_len
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    TERM = 2'b10
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = 1;
  localparam logic [ADDR_WIDTH:0]   LEN_ONE   = 1;

  localparam logic [1:0] ERR_OVERFLOW = 2'b01;
  localparam logic [1:0] ERR_CLOSE    = 2'b10;
  localparam logic [1:0] ERR_OPEN     = 2'b11;

  state_t                state, stateNext;
  logic [ADDR_WIDTH-1:0] pointer, pointerNext;
  logic [ADDR_WIDTH-1:0] depth, depthNext;
  logic                  wrEnNext;
  logic [ADDR_WIDTH-1:0] addrNext;
  logic [7:0]            wrDataNext;
  logic                  doneNext;
  logic                  errorNext;
  logic [1:0]            errCodeNext;
  logic [ADDR_WIDTH:0]   progLenNext;
  logic                  accept;

  function automatic logic isCommand(input logic [7:0] b);
    case (b)
      8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C: return 1'b1;
      default:                                                return 1'b0;
    endcase
  endfunction

  assign in_ready = (state == LOAD);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    stateNext   = state;
    pointerNext = pointer;
    depthNext   = depth;
    wrEnNext    = 1'b0;
    addrNext    = mem_addr;
    wrDataNext  = mem_wr_data;
    doneNext    = 1'b0;
    errorNext   = error;
    errCodeNext = err_code;
    progLenNext = prog_len;

    case (state)
      IDLE: begin
        if (start) begin
          stateNext   = LOAD;
          pointerNext = '0;
          depthNext   = '0;
          progLenNext = '0;
          errorNext   = 1'b0;
          errCodeNext = 2'b00;
        end
      end

      LOAD: begin
        if (accept) begin
          if (in_data == 8'h00) begin
            if (depth != '0) begin
              stateNext   = IDLE;
              doneNext    = 1'b1;
              errorNext   = 1'b1;
              errCodeNext = ERR_OPEN;
            end else begin
              // Terminator goes at the current pointer; done follows from TERM.
              stateNext  = TERM;
              wrEnNext   = 1'b1;
              addrNext   = pointer;
              wrDataNext = 8'h00;
            end
          end else if (isCommand(in_data)) begin
            if (in_data == 8'h5D && depth == '0) begin
              stateNext   = IDLE;
              doneNext    = 1'b1;
              errorNext   = 1'b1;
              errCodeNext = ERR_CLOSE;
            end else if (pointer == LAST_ADDR) begin
              // Last address is reserved for the terminator.
              stateNext   = IDLE;
              doneNext    = 1'b1;
              errorNext   = 1'b1;
              errCodeNext = ERR_OVERFLOW;
            end else begin
              wrEnNext    = 1'b1;
              addrNext    = pointer;
              wrDataNext  = in_data;
              pointerNext = pointer + PTR_ONE;
              progLenNext = prog_len + LEN_ONE;
              if (in_data == 8'h5B) depthNext = depth + PTR_ONE;
              if (in_data == 8'h5D) depthNext = depth - PTR_ONE;
            end
          end
        end
      end

      TERM: begin
        stateNext = IDLE;
        doneNext  = 1'b1;
      end

      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pointer     <= '0;
      depth       <= '0;
      mem_wr_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= 8'h00;
      done        <= 1'b0;
      error       <= 1'b0;
      err_code    <= 2'b00;
      prog_len    <= '0;
    end else begin
      state       <= stateNext;
      pointer     <= pointerNext;
      depth       <= depthNext;
      mem_wr_en   <= wrEnNext;
      mem_addr    <= addrNext;
      mem_wr_data <= wrDataNext;
      done        <= doneNext;
      error       <= errorNext;
      err_code    <= errCodeNext;
      prog_len    <= progLenNext;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader (ADDR_WIDTH=4). Each vector holds the inputs
// for one cycle and the outputs expected in the following cycle.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       mem_wr_en;
  logic [3:0] mem_addr;
  logic [7:0] mem_wr_data;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] err_code;
  logic [4:0] prog_len;

  always #5 clk = ~clk;

  program_loader #(.ADDR_WIDTH(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .err_code    (err_code),
    .prog_len    (prog_len)
  );

  typedef struct {
    logic       st;
    logic       vl;
    logic [7:0] d;
    logic       wr;
    logic [3:0] a;
    logic [7:0] wd;
    logic       dn;
    logic       er;
    logic [1:0] ec;
    logic       bs;
    logic       rd;
    logic [4:0] ln;
  } vec_t;

  vec_t vecs[$];
  int   nChecks = 0;
  int   nPass   = 0;

  logic [7:0] prog1 [11] = '{8'h2B, 8'h5B, 8'h2E, 8'h2B, 8'h5D, 8'h3E,
                             8'h2D, 8'h5B, 8'h2E, 8'h2D, 8'h5D};

  function automatic vec_t mk(input logic st, input logic vl, input logic [7:0] d,
                              input logic wr, input logic [3:0] a, input logic [7:0] wd,
                              input logic dn, input logic er, input logic [1:0] ec,
                              input logic bs, input logic rd, input logic [4:0] ln);
    vec_t v;
    v.st = st; v.vl = vl; v.d = d;
    v.wr = wr; v.a = a; v.wd = wd;
    v.dn = dn; v.er = er; v.ec = ec;
    v.bs = bs; v.rd = rd; v.ln = ln;
    return v;
  endfunction

  // Address/data are only compared while a write is expected.
  task automatic checkOut(input string name, input vec_t v);
    logic [23:0] act;
    logic [23:0] exp;
    act = {mem_wr_en, v.wr ? mem_addr : 4'h0, v.wr ? mem_wr_data : 8'h00,
           done, error, err_code, busy, in_ready, prog_len};
    exp = {v.wr, v.a, v.wd, v.dn, v.er, v.ec, v.bs, v.rd, v.ln};
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got wr/addr/data/done/err/code/busy/rdy/len=%h required %h",
                  name, act, exp);
  endtask

  task automatic applyVec(input string name, input vec_t v);
    start    = v.st;
    in_valid = v.vl;
    in_data  = v.d;
    @(posedge clk);
    #1;
    checkOut(name, v);
  endtask

  initial begin
    vec_t zero;
    zero = mk(0, 0, 8'h00, 0, 4'h0, 8'h00, 0, 0, 2'b00, 0, 0, 5'd0);

    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Full well-formed program with nested brackets.
    vecs.push_back(mk(1, 0, 8'h00, 0, 4'h0, 8'h00, 0, 0, 2'b00, 1, 1, 5'd0));
    for (int i = 0; i < 11; i++)
      vecs.push_back(mk(0, 1, prog1[i], 1, 4'(i), prog1[i], 0, 0, 2'b00, 1, 1, 5'(i + 1)));
    vecs.push_back(mk(0, 1, 8'h00, 1, 4'd11, 8'h00, 0, 0, 2'b00, 1, 0, 5'd11));
    vecs.push_back(mk(1, 0, 8'h00, 0, 4'h0, 8'h00, 1, 0, 2'b00, 0, 0, 5'd11));
    vecs.push_back(mk(0, 0, 8'h00, 0, 4'h0, 8'h00, 0, 0, 2'b00, 0, 0, 5'd11));

    // Non-command bytes and in_valid gaps.
    vecs.push_back(mk(1, 0, 8'h00, 0, 4'h0, 8'h00, 0, 0, 2'b00, 1, 1, 5'd0));
    vecs.push_back(mk(0, 1, 8'h2B, 1, 4'd0, 8'h2B, 0, 0, 2'b00, 1, 1, 5'd1));
    vecs.push_back(mk(0, 0, 8'h2D, 0, 4'h0, 8'h00, 0, 0, 2'b00, 1, 1, 5'd1));
    vecs.push_back(mk(0, 1, 8'h20, 0, 4'h0, 8'h00, 0, 0, 2'b00, 1, 1, 5'd1));
    vecs.push_back(mk(0, 1, 8'h61, 0, 4'h0, 8'h00, 0, 0, 2'b00, 1, 1, 5'd1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 4'h0, 8'h00, 0, 0, 2'b00, 1, 1, 5'd1));
    vecs.push_back(mk(0, 1, 8'h0A, 0, 4'h0, 8'h00, 0, 0, 2'b00, 1, 1, 5'd1));
    vecs.push_back(mk(0, 1, 8'h2D, 1, 4'd1, 8'h2D, 0, 0, 2'b00, 1, 1, 5'd2));
    vecs.push_back(mk(0, 0, 8'h00, 0, 4'h0, 8'h00, 0, 0, 2'b00, 1, 1, 5'd2));
    vecs.push_back(mk(0, 1, 8'h00, 1, 4'd2, 8'h00, 0, 0, 2'b00, 1, 0, 5'd2));
    vecs.push_back(mk(0, 0, 8'h00, 0, 4'h0, 8'h00, 1, 0, 2'b00, 0, 0, 5'd2));

    // Unmatched ']' as the first byte; error held afterwards in IDLE.
    vecs.push_back(mk(1, 0, 8'h00, 0, 4'h0, 8'h00, 0, 0, 2'b00, 1, 1, 5'd0));
    vecs.push_back(mk(0, 1, 8'h5D, 0, 4'h0, 8'h00, 1, 1, 2'b10, 0, 0, 5'd0));
    vecs.push_back(mk(0, 1, 8'h2B, 0, 4'h0, 8'h00, 0, 1, 2'b10, 0, 0, 5'd0));

    // Unmatched '[' at the terminator; start clears the previous error.
    vecs.push_back(mk(1, 0, 8'h00, 0, 4'h0, 8'h00, 0, 0, 2'b00, 1, 1, 5'd0));
    vecs.push_back(mk(0, 1, 8'h5B, 1, 4'd0, 8'h5B, 0, 0, 2'b00, 1, 1, 5'd1));
    vecs.push_back(mk(0, 1, 8'h5B, 1, 4'd1, 8'h5B, 0, 0, 2'b00, 1, 1, 5'd2));
    vecs.push_back(mk(0, 1, 8'h00, 0, 4'h0, 8'h00, 1, 1, 2'b11, 0, 0, 5'd2));
    vecs.push_back(mk(0, 0, 8'h00, 0, 4'h0, 8'h00, 0, 1, 2'b11, 0, 0, 5'd2));

    // Overflow: 16 commands, start pulsed during LOAD.
    vecs.push_back(mk(1, 0, 8'h00, 0, 4'h0, 8'h00, 0, 0, 2'b00, 1, 1, 5'd0));
    for (int i = 0; i < 15; i++)
      vecs.push_back(mk((i == 3 || i == 9), 1, 8'h2B, 1, 4'(i), 8'h2B,
                        0, 0, 2'b00, 1, 1, 5'(i + 1)));
    vecs.push_back(mk(1, 1, 8'h2B, 0, 4'h0, 8'h00, 1, 1, 2'b01, 0, 0, 5'd15));
    vecs.push_back(mk(0, 0, 8'h00, 0, 4'h0, 8'h00, 0, 1, 2'b01, 0, 0, 5'd15));

    #12;
    checkOut("reset_state", zero);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) applyVec($sformatf("vec%0d", i), vecs[i]);

    // Mid-session asynchronous reset, then a fresh session from address 0.
    applyVec("rst_start", mk(1, 0, 8'h00, 0, 4'h0, 8'h00, 0, 0, 2'b00, 1, 1, 5'd0));
    applyVec("rst_cmd0",  mk(0, 1, 8'h2B, 1, 4'd0, 8'h2B, 0, 0, 2'b00, 1, 1, 5'd1));
    applyVec("rst_cmd1",  mk(0, 1, 8'h3E, 1, 4'd1, 8'h3E, 0, 0, 2'b00, 1, 1, 5'd2));
    applyVec("rst_cmd2",  mk(0, 1, 8'h2D, 1, 4'd2, 8'h2D, 0, 0, 2'b00, 1, 1, 5'd3));
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checkOut("async_reset", zero);
    @(posedge clk);
    #1;
    checkOut("reset_held", zero);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    applyVec("re_start", mk(1, 0, 8'h00, 0, 4'h0, 8'h00, 0, 0, 2'b00, 1, 1, 5'd0));
    applyVec("re_cmd",   mk(0, 1, 8'h2E, 1, 4'd0, 8'h2E, 0, 0, 2'b00, 1, 1, 5'd1));
    applyVec("re_term",  mk(0, 1, 8'h00, 1, 4'd1, 8'h00, 0, 0, 2'b00, 1, 0, 5'd1));
    applyVec("re_done",  mk(0, 0, 8'h00, 0, 4'h0, 8'h00, 1, 0, 2'b00, 0, 0, 5'd1));

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
